// File: rtl/div_unit_if.sv
// Handshake and operand bus between the EX stage (master) and the multi-cycle divider (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider, one quotient bit per clock; signed operands are divided
// as magnitudes and the signs are reapplied when the result is finalised.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic                  sign1_q, sign1_d;
  logic                  sign2_q, sign2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic [DATA_W:0]       rem_shift_s;
  logic [DATA_W:0]       diff_s;
  logic [DATA_W-1:0]     quo_fin_s;
  logic [DATA_W-1:0]     rem_fin_s;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, iteration step and result finalisation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    result_d    = result_q;
    ready_d     = ready_q;
    // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
    rem_shift_s = {rem_q, dvd_q[DATA_W-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_q};
    quo_fin_s   = (sign1_q ^ sign2_q) ? negate(dvd_q) : dvd_q;
    rem_fin_s   = sign1_q ? negate(rem_q) : rem_q;

    case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          sign1_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
          sign2_d = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
          dvd_d   = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? negate(bus.opdata1_i) : bus.opdata1_i;
          dvs_d   = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? negate(bus.opdata2_i) : bus.opdata2_i;
          rem_d   = '0;
          cnt_d   = '0;
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
          end
        end else begin
          state_d = FREE;
        end
      end
      BYZERO: begin
        result_d = '0;
        if (bus.annul_i) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!diff_s[DATA_W]) begin
            rem_d = diff_s[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift_s[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          state_d  = END;
          result_d = {rem_fin_s, quo_fin_s};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (bus.start_i) begin
          state_d = END;
        end else begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
